// File: rtl/fxp_mul_pipe.sv
// Signed fixed-point multiplier: radix-4 Booth, carry-save reduction, rounding and range check in a 4-stage stall-able pipeline.
// Optional macro FXP_MUL_SAT_EN: clamp overflowed results instead of wrapping them.
module fxp_mul_pipe #(
  parameter int W     = 24,
  parameter int FRAC  = 22,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_rnd,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_sat,
  output logic [TAG_W-1:0] out_tag,
  input  logic             clr_sticky,
  output logic             sat_sticky,
  output logic [15:0]      sat_cnt
);
  localparam int NPP = W / 2;
  localparam int PW  = 2 * W;
  localparam int RW  = 2 * W + 2;

  logic             w_adv;
  logic             r_s1_v, r_s2_v, r_s3_v, r_out_valid;
  logic [W-1:0]     r_s1_a, r_s1_b;
  logic [1:0]       r_s1_rnd, r_s2_rnd, r_s3_rnd;
  logic [TAG_W-1:0] r_s1_tag, r_s2_tag, r_s3_tag, r_out_tag;
  logic [PW-1:0]    r_s2_pp [NPP];
  logic [PW-1:0]    r_s3_sum, r_s3_car;
  logic [W-1:0]     r_out_data;
  logic             r_out_sat, r_sticky;
  logic [15:0]      r_cnt;

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_tag   = r_out_tag;
  assign sat_sticky = r_sticky;
  assign sat_cnt   = r_cnt;

  // Booth recoding of a; each digit selects 0, +-b or +-2b shifted into place
  logic [PW-1:0] w_pp [NPP];
  logic [PW-1:0] w_b1, w_b2;
  assign w_b1 = {{W{r_s1_b[W-1]}}, r_s1_b};
  assign w_b2 = w_b1 << 1;

  generate
    for (genvar gi = 0; gi < NPP; gi++) begin : g_booth
      logic [2:0]    w_sel;
      logic [PW-1:0] w_mag;
      if (gi == 0) begin : g_lsb
        assign w_sel = {r_s1_a[1:0], 1'b0};
      end else begin : g_mid
        assign w_sel = r_s1_a[2*gi+1 : 2*gi-1];
      end
      always_comb begin
        w_mag = '0;
        case (w_sel)
          3'b001, 3'b010: w_mag = w_b1;
          3'b011:         w_mag = w_b2;
          3'b100:         w_mag = -w_b2;
          3'b101, 3'b110: w_mag = -w_b1;
          default:        w_mag = '0;
        endcase
      end
      assign w_pp[gi] = w_mag << (2 * gi);
    end
  endgenerate

  // Carry-save accumulation of all partial products into sum/carry vectors
  logic [PW-1:0] w_sum, w_car, w_tmp;
  always_comb begin
    w_sum = r_s2_pp[0];
    w_car = '0;
    w_tmp = '0;
    for (int i = 1; i < NPP; i++) begin
      w_tmp = w_sum ^ w_car ^ r_s2_pp[i];
      w_car = ((w_sum & w_car) | (w_sum & r_s2_pp[i]) | (w_car & r_s2_pp[i])) << 1;
      w_sum = w_tmp;
    end
  end

  // Final add, rounding bias, arithmetic shift and range check
  logic [PW-1:0]        w_p;
  logic [RW-1:0]        w_pe, w_half, w_bias;
  logic signed [RW-1:0] w_sumr, w_r;
  logic                 w_ovf;
  logic [W-1:0]         w_res;

  assign w_p    = r_s3_sum + r_s3_car;
  assign w_pe   = {{2{w_p[PW-1]}}, w_p};
  assign w_half = RW'(1) << (FRAC - 1);

  always_comb begin
    w_bias = '0;
    case (r_s3_rnd)
      2'd1:    w_bias = w_half;
      2'd2:    w_bias = w_half - RW'(1) + {{(RW-1){1'b0}}, w_p[FRAC]};
      default: w_bias = '0;
    endcase
  end

  assign w_sumr = w_pe + w_bias;
  assign w_r    = w_sumr >>> FRAC;
  assign w_ovf  = !((&w_r[RW-1:W-1]) || !(|w_r[RW-1:W-1]));

`ifdef FXP_MUL_SAT_EN
  assign w_res = w_ovf ? (w_r[RW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                       : w_r[W-1:0];
`else
  assign w_res = w_r[W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0; r_s2_v <= 1'b0; r_s3_v <= 1'b0; r_out_valid <= 1'b0;
      r_s1_a <= '0; r_s1_b <= '0; r_s1_rnd <= '0; r_s1_tag <= '0;
      r_s2_rnd <= '0; r_s2_tag <= '0;
      for (int i = 0; i < NPP; i++) r_s2_pp[i] <= '0;
      r_s3_sum <= '0; r_s3_car <= '0; r_s3_rnd <= '0; r_s3_tag <= '0;
      r_out_data <= '0; r_out_sat <= 1'b0; r_out_tag <= '0;
    end else if (w_adv) begin
      r_s1_v   <= in_valid;
      r_s1_a   <= in_a;
      r_s1_b   <= in_b;
      r_s1_rnd <= in_rnd;
      r_s1_tag <= in_tag;
      r_s2_v   <= r_s1_v;
      r_s2_rnd <= r_s1_rnd;
      r_s2_tag <= r_s1_tag;
      for (int i = 0; i < NPP; i++) r_s2_pp[i] <= w_pp[i];
      r_s3_v   <= r_s2_v;
      r_s3_sum <= w_sum;
      r_s3_car <= w_car;
      r_s3_rnd <= r_s2_rnd;
      r_s3_tag <= r_s2_tag;
      r_out_valid <= r_s3_v;
      // a bubble leaves the last result's data/tag/sat in place
      if (r_s3_v) begin
        r_out_data <= w_res;
        r_out_sat  <= w_ovf;
        r_out_tag  <= r_s3_tag;
      end
    end
  end

  // Clear takes effect first so a coincident overflow still counts once
  logic        w_load_ovf;
  logic [15:0] w_cnt_base;
  assign w_load_ovf = w_adv && r_s3_v && w_ovf;
  assign w_cnt_base = clr_sticky ? 16'd0 : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sticky <= w_load_ovf ? 1'b1 : (clr_sticky ? 1'b0 : r_sticky);
      r_cnt    <= (w_load_ovf && w_cnt_base != 16'hFFFF) ? w_cnt_base + 16'd1 : w_cnt_base;
    end
  end
endmodule

// File: doc/fxp_mul_pipe.md
# fxp_mul_pipe

Parametrised signed fixed-point multiplier: radix-4 Booth partial products, carry-save reduction and final add in a 4-stage pipeline with valid/ready backpressure. Per-operation rounding mode, saturation with per-result flag, sticky flag and event counter, and a sideband tag. It is the general multiplier for the IIR datapath, serving any coefficient/sample format and downstream consumers that can stall.

## Interface
- W, 24: operand and result width (signed, two's complement); even, 8..32.
- FRAC, 22: fraction bits of operands and result (QW-FRAC.FRAC); 1 ≤ FRAC ≤ W-1.
- TAG_W, 4: sideband tag width, ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_a  in  W  multiplicand.
- in_b  in  W  multiplier.
- in_rnd  in  2  rounding mode: 0 floor, 1 half-up, 2 convergent (half-to-even), 3 treated as 0.
- in_tag  in  TAG_W  carried unchanged to out_tag.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  rounded, saturated product.
- out_sat  out  1  this result overflowed the W-bit range.
- out_tag  out  TAG_W  tag of this result.
- clr_sticky  in  1  synchronous clear of sat_sticky and sat_cnt.
- sat_sticky  out  1  set by any overflowed result since last clear.
- sat_cnt  out  16  overflowed-result count, saturates at 0xFFFF.

## Operation
- Accept: beat transfers when in_valid && in_ready.
- Global stall: adv = !out_valid || out_ready; in_ready = adv. All stages (S1..S4) advance only when adv; every stage carries its own valid bit, bubbles propagate as invalid.
- S1: register a, b, rnd, tag. S2: W/2 Booth digits of a (sign-extended, implicit 0 below LSB), partial products 2W bits, registered. S3: 3:2 compressor tree to two 2W-bit vectors, registered. S4: final add gives exact product P (2W bits); round; range check; register into output.
- Rounding on P with shift FRAC: mode 0 R = P>>>FRAC; mode 1 R = (P + 2^(FRAC-1))>>>FRAC; mode 2 R = (P + 2^(FRAC-1) - 1 + P[FRAC])>>>FRAC. Internal width ≥ 2W+1, no intermediate wrap.
- Overflow: R outside [-2^(W-1), 2^(W-1)-1]. out_sat = overflow for that result.
- sat_sticky/sat_cnt update when an overflowed result loads the output register. clr_sticky coincident with such a load: clear applied, then event counted (sticky=1, cnt=1).
- Bubble into output register: out_valid drops, out_data/out_tag/out_sat hold last values.

## Timing
- Latency: 4 clk edges from accepting edge to out_valid high, with no stall.
- Throughput: 1 result/cycle while out_ready high.
- Stall: out_valid && !out_ready freezes all stages and holds out_* stable; in_ready low that cycle (combinational from out_ready and out_valid).
- Reset (async, any time, including mid-stall): all stage valids 0, out_valid 0, out_data 0, out_tag 0, out_sat 0, sat_sticky 0, sat_cnt 0; in-flight beats discarded; in_ready 1 after reset.
- No combinational path from in_* to out_*.

## Configuration
- FXP_MUL_SAT_EN defined: overflowed results clamp to 2^(W-1)-1 (positive) or -2^(W-1) (negative).
- Not defined: out_data = R[W-1:0] (wrap). out_sat, sat_sticky, sat_cnt still report overflow identically.

## Test plan
- W=24, FRAC=22, mode 0: a=0x400000, b=0x400000 -> out_data 0x400000, out_sat 0, valid 4 cycles after accept; a=0x400000, b=0xC00000 -> 0xC00000.
- Rounding, b=0x200000: a=0x000001 -> modes 0/1/2 give 0x000000/0x000001/0x000000; a=0x000003 -> 0x000001/0x000002/0x000002; a=0xFFFFFF -> 0xFFFFFF/0x000000/0x000000.
- Overflow with FXP_MUL_SAT_EN: a=b=0x800000 -> 0x7FFFFF, out_sat 1; a=0x800000, b=0x600000 -> 0x800000, out_sat 1; sat_cnt=2, sat_sticky 1; pulse clr_sticky -> both 0. Without macro, first case -> 0x000000, out_sat 1.
- Backpressure: 8 back-to-back beats, tags 0..7, out_ready low cycles 6-9 -> in_ready low those cycles, out_* stable, all 8 results in tag order, none lost or duplicated.
- Random: 10k random a/b/rnd/tag with random out_ready vs. reference model -> bit-exact data, sat, tag; sat_cnt equals overflow count.
- Reset with 3 beats in flight and output stalled -> all outputs at reset values, no stale result after rst_n release.
